// File: rtl/auto_nav_pkg.sv
// Shared definitions for the autonomous-navigation sequencer: state and
// moving-state codes, detector bit masks and the right-hand-wall decision rule.
package auto_nav_pkg;

    typedef enum logic [1:0] {
        ST_WAITING = 2'b00,
        ST_MOVING  = 2'b01,
        ST_TURNING = 2'b10,
        ST_COOLING = 2'b11
    } nav_state_e;

    typedef enum logic [3:0] {
        MV_STOP       = 4'b0000,
        MV_FORWARD    = 4'b0001,
        MV_TURN_LEFT  = 4'b0100,
        MV_TURN_RIGHT = 4'b1000
    } move_state_e;

    // Detector flags: 1 = blocked
    localparam logic [3:0] DET_FRONT = 4'b0001;
    localparam logic [3:0] DET_BACK  = 4'b0010;
    localparam logic [3:0] DET_RIGHT = 4'b0100;
    localparam logic [3:0] DET_LEFT  = 4'b1000;

    localparam logic [1:0] GS_AUTO = 2'b01;

    typedef struct packed {
        move_state_e dir;    // MV_FORWARD, MV_TURN_LEFT or MV_TURN_RIGHT
        logic        uturn;  // dead end: turn lasts twice as long
    } nav_decision_t;

    // Right-hand-wall rule; the back detector never influences the choice.
    function automatic nav_decision_t nav_decide(input logic [3:0] det);
        nav_decision_t d;
        d.uturn = 1'b0;
        if ((det & DET_RIGHT) == 4'b0000) begin
            d.dir = MV_TURN_RIGHT;
        end else if ((det & DET_FRONT) == 4'b0000) begin
            d.dir = MV_FORWARD;
        end else if ((det & DET_LEFT) == 4'b0000) begin
            d.dir = MV_TURN_LEFT;
        end else begin
            d.dir   = MV_TURN_RIGHT;
            d.uturn = 1'b1;
        end
        return d;
    endfunction

    // A junction has at least two of front/right/left open.
    function automatic logic nav_is_junction(input logic [3:0] det);
        logic [1:0] n_open;
        n_open = {1'b0, ((det & DET_FRONT) == 4'b0000)}
               + {1'b0, ((det & DET_RIGHT) == 4'b0000)}
               + {1'b0, ((det & DET_LEFT)  == 4'b0000)};
        return (n_open >= 2'd2);
    endfunction

endpackage

// File: rtl/nav_tick_gen.sv
// Free-running timebase: one-cycle tick every CLK_FREQ_HZ/TICK_HZ clocks,
// restarting its phase whenever reset is applied.
module nav_tick_gen #(
    parameter int CLK_FREQ_HZ = 100000000,
    parameter int TICK_HZ     = 50
) (
    input  logic sys_clk,
    input  logic rst,
    output logic tick
);

    localparam int DIV = CLK_FREQ_HZ / TICK_HZ;
    localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] r_cnt;
    logic          r_tick;

    // Divide sys_clk down and emit a registered single-cycle tick on wrap
    always_ff @(posedge sys_clk or negedge rst) begin
        if (!rst) begin
            r_cnt  <= {CW{1'b0}};
            r_tick <= 1'b0;
        end else if (r_cnt == LAST) begin
            r_cnt  <= {CW{1'b0}};
            r_tick <= 1'b1;
        end else begin
            r_cnt  <= r_cnt + CW'(1);
            r_tick <= 1'b0;
        end
    end

    assign tick = r_tick;

endmodule

// File: rtl/auto_nav_sequencer.sv
// Autonomous-mode sequencer: turns synchronised obstacle detectors into a
// timed WAITING / MOVING / TURNING / COOLING sequence for the motion datapath.
// Optional macro AUTO_BEACON_EN: pulse pl_beacon_sig when a turn starts at a
// junction; when undefined the output is tied low.
module auto_nav_sequencer
    import auto_nav_pkg::*;
#(
    parameter int CLK_FREQ_HZ = 100000000,
    parameter int TICK_HZ     = 50,
    parameter int TURN_TICKS  = 45,
    parameter int COOL_TICKS  = 25
) (
    input  logic       sys_clk,
    input  logic       rst,
    input  logic       power,
    input  logic [1:0] global_state,
    input  logic [3:0] detectors,
    output logic [1:0] state,
    output logic [3:0] moving_state,
    output logic       pl_beacon_sig
);

    localparam int TCW = $clog2(2 * TURN_TICKS + 1);
    localparam int CCW = (COOL_TICKS > 1) ? $clog2(COOL_TICKS) : 1;
    localparam logic [TCW-1:0] TURN_LAST_N = TCW'(TURN_TICKS - 1);
    localparam logic [TCW-1:0] TURN_LAST_U = TCW'(2 * TURN_TICKS - 1);
    localparam logic [CCW-1:0] COOL_LAST   = CCW'(COOL_TICKS - 1);

    logic [3:0]     r_sync1;
    logic [3:0]     r_det;
    nav_state_e     r_state;
    move_state_e    r_move;
    logic           r_uturn;
    logic [3:0]     r_latch;
    logic [TCW-1:0] r_turn_cnt;
    logic [CCW-1:0] r_cool_cnt;

    logic           w_tick;
    logic           w_en;
    nav_decision_t  w_dec;
    logic           w_front_blk;
    logic           w_reeval;
    logic           w_enter_turn;
    logic           w_turn_last;
    logic           w_cool_last;

    nav_tick_gen #(
        .CLK_FREQ_HZ (CLK_FREQ_HZ),
        .TICK_HZ     (TICK_HZ)
    ) u_tick (
        .sys_clk (sys_clk),
        .rst     (rst),
        .tick    (w_tick)
    );

    assign w_en         = power & (global_state == GS_AUTO);
    assign w_dec        = nav_decide(r_det);
    assign w_front_blk  = (r_det & DET_FRONT) != 4'b0000;
    assign w_reeval     = (r_det != r_latch) | w_front_blk;
    assign w_enter_turn = ((r_state == ST_WAITING) | ((r_state == ST_MOVING) & w_reeval))
                        & (w_dec.dir != MV_FORWARD);
    assign w_turn_last  = r_turn_cnt == (r_uturn ? TURN_LAST_U : TURN_LAST_N);
    assign w_cool_last  = r_cool_cnt == COOL_LAST;

    // Two-flop synchroniser for the asynchronous detector inputs
    always_ff @(posedge sys_clk or negedge rst) begin
        if (!rst) begin
            r_sync1 <= 4'b0000;
            r_det   <= 4'b0000;
        end else begin
            r_sync1 <= detectors;
            r_det   <= r_sync1;
        end
    end

    // Navigation FSM with turn/cool timers; loss of enable overrides everything
    always_ff @(posedge sys_clk or negedge rst) begin
        if (!rst) begin
            r_state    <= ST_WAITING;
            r_move     <= MV_STOP;
            r_uturn    <= 1'b0;
            r_latch    <= 4'b0000;
            r_turn_cnt <= {TCW{1'b0}};
            r_cool_cnt <= {CCW{1'b0}};
        end else if (!w_en) begin
            r_state    <= ST_WAITING;
            r_move     <= MV_STOP;
            r_uturn    <= 1'b0;
            r_latch    <= 4'b0000;
            r_turn_cnt <= {TCW{1'b0}};
            r_cool_cnt <= {CCW{1'b0}};
        end else begin
            case (r_state)
                ST_WAITING, ST_MOVING: begin
                    if (w_enter_turn) begin
                        r_state    <= ST_TURNING;
                        r_move     <= w_dec.dir;
                        r_uturn    <= w_dec.uturn;
                        r_turn_cnt <= {TCW{1'b0}};
                        r_latch    <= r_det;
                    end else if ((r_state == ST_WAITING) || w_reeval) begin
                        r_state <= ST_MOVING;
                        r_move  <= MV_FORWARD;
                        r_latch <= r_det;
                    end else begin
                        r_move  <= MV_FORWARD;
                    end
                end
                ST_TURNING: begin
                    if (w_tick && w_turn_last) begin
                        r_state    <= ST_COOLING;
                        r_move     <= MV_FORWARD;
                        r_cool_cnt <= {CCW{1'b0}};
                    end else if (w_tick) begin
                        r_turn_cnt <= r_turn_cnt + TCW'(1);
                    end else begin
                        r_turn_cnt <= r_turn_cnt;
                    end
                end
                ST_COOLING: begin
                    // Only the front detector may cut the cool-down short
                    if (w_front_blk || (w_tick && w_cool_last)) begin
                        r_state <= ST_MOVING;
                        r_move  <= MV_FORWARD;
                        r_latch <= r_det;
                    end else if (w_tick) begin
                        r_cool_cnt <= r_cool_cnt + CCW'(1);
                    end else begin
                        r_cool_cnt <= r_cool_cnt;
                    end
                end
                default: begin
                    r_state <= ST_WAITING;
                    r_move  <= MV_STOP;
                end
            endcase
        end
    end

    assign state        = r_state;
    assign moving_state = r_move;

`ifdef AUTO_BEACON_EN
    logic r_beacon;

    // One-cycle beacon on entry to TURNING from a junction (never for a U-turn)
    always_ff @(posedge sys_clk or negedge rst) begin
        if (!rst) begin
            r_beacon <= 1'b0;
        end else begin
            r_beacon <= w_en & w_enter_turn & ~w_dec.uturn & nav_is_junction(r_det);
        end
    end

    assign pl_beacon_sig = r_beacon;
`else
    assign pl_beacon_sig = 1'b0;
`endif

endmodule

// File: tb/tb_auto_nav_sequencer.sv
// Directed bench for auto_nav_sequencer: expected (state, moving_state,
// beacon, dwell window) transitions are queued as stimulus is applied and
// checked as the DUT outputs change.
module tb_auto_nav_sequencer;

    localparam int CLK_FREQ_HZ = 1000;
    localparam int TICK_HZ     = 100;
    localparam int TURN_TICKS  = 4;
    localparam int COOL_TICKS  = 3;

    localparam logic [1:0] S_WAIT = 2'b00;
    localparam logic [1:0] S_MOVE = 2'b01;
    localparam logic [1:0] S_TURN = 2'b10;
    localparam logic [1:0] S_COOL = 2'b11;
    localparam logic [3:0] M_STOP = 4'b0000;
    localparam logic [3:0] M_FWD  = 4'b0001;
    localparam logic [3:0] M_LEFT = 4'b0100;
    localparam logic [3:0] M_RGHT = 4'b1000;

`ifdef AUTO_BEACON_EN
    localparam logic BEACON_BUILD = 1'b1;
`else
    localparam logic BEACON_BUILD = 1'b0;
`endif

    typedef struct {
        logic [1:0] st;
        logic [3:0] mv;
        logic       bcn;
        int         dmin;
        int         dmax;
        string      tag;
    } exp_t;

    logic       sys_clk = 1'b0;
    logic       rst = 1'b0;
    logic       power = 1'b0;
    logic [1:0] global_state = 2'b01;
    logic [3:0] detectors = 4'b0001;
    logic [1:0] state;
    logic [3:0] moving_state;
    logic       pl_beacon_sig;

    exp_t       sb[$];
    int         checks = 0;
    int         errors = 0;
    int         cycle = 0;
    int         last_cyc = 0;
    logic [1:0] last_st = 2'b00;
    logic [3:0] last_mv = 4'b0000;

    auto_nav_sequencer #(
        .CLK_FREQ_HZ (CLK_FREQ_HZ),
        .TICK_HZ     (TICK_HZ),
        .TURN_TICKS  (TURN_TICKS),
        .COOL_TICKS  (COOL_TICKS)
    ) dut (
        .sys_clk       (sys_clk),
        .rst           (rst),
        .power         (power),
        .global_state  (global_state),
        .detectors     (detectors),
        .state         (state),
        .moving_state  (moving_state),
        .pl_beacon_sig (pl_beacon_sig)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [1:0] st, input logic [3:0] mv, input logic bcn,
                        input int dmin, input int dmax, input string tag);
        exp_t e;
        e.st = st; e.mv = mv; e.bcn = bcn; e.dmin = dmin; e.dmax = dmax; e.tag = tag;
        sb.push_back(e);
    endtask

    // One clock: sample on the falling edge, score any output change
    task automatic cyc();
        exp_t e;
        logic exp_b;
        int   d;
        @(negedge sys_clk);
        cycle++;
        exp_b = 1'b0;
        if ({state, moving_state} !== {last_st, last_mv}) begin
            checks++;
            assert (sb.size() != 0) else begin
                errors++;
                $error("FAIL unexpected_transition: observed=%0h expected=%0h",
                       {state, moving_state}, {last_st, last_mv});
            end
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk({e.tag, "_state"}, {30'b0, state}, {30'b0, e.st});
                chk({e.tag, "_moving"}, {28'b0, moving_state}, {28'b0, e.mv});
                d = cycle - last_cyc;
                checks++;
                assert (d >= e.dmin && d <= e.dmax) else begin
                    errors++;
                    $error("FAIL %s_dwell: observed=%0d expected=%0d..%0d", e.tag, d, e.dmin, e.dmax);
                end
                exp_b = e.bcn;
            end
            last_st  = state;
            last_mv  = moving_state;
            last_cyc = cycle;
        end
        chk("beacon", {31'b0, pl_beacon_sig}, {31'b0, exp_b});
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    task automatic drain(input string tag, input int max);
        for (int i = 0; i < max && sb.size() != 0; i++) cyc();
        checks++;
        assert (sb.size() == 0) else begin
            errors++;
            $error("FAIL %s_timeout: observed=%0d pending expected=0", tag, sb.size());
        end
        sb.delete();
    endtask

    initial begin
        // Reset state
        #22;
        chk("rst_state", {30'b0, state}, {30'b0, S_WAIT});
        chk("rst_moving", {28'b0, moving_state}, {28'b0, M_STOP});
        chk("rst_beacon", {31'b0, pl_beacon_sig}, 32'd0);
        @(negedge sys_clk);
        #2 rst = 1'b1;
        run(5);

        // 1: front blocked -> right turn, cool-down, then moving
        power = 1'b1; last_cyc = cycle;
        push(S_TURN, M_RGHT, BEACON_BUILD, 1, 1, "t1_turn");
        drain("t1a", 5);
        detectors = 4'b0100;
        push(S_COOL, M_FWD, 1'b0, 31, 40, "t1_cool");
        push(S_MOVE, M_FWD, 1'b0, 30, 30, "t1_move");
        drain("t1b", 100);

        // 2: right wall with open front -> straight ahead for 20 ticks
        power = 1'b0; last_cyc = cycle;
        push(S_WAIT, M_STOP, 1'b0, 1, 1, "t2_off");
        drain("t2a", 5);
        power = 1'b1; last_cyc = cycle;
        push(S_MOVE, M_FWD, 1'b0, 1, 1, "t2_move");
        drain("t2b", 5);
        run(200);
        chk("t2_hold", {30'b0, state}, {30'b0, S_MOVE});

        // 3: dead end while moving -> U-turn of twice the length, no beacon
        detectors = 4'b1101; last_cyc = cycle;
        push(S_TURN, M_RGHT, 1'b0, 3, 3, "t3_uturn");
        drain("t3a", 10);
        detectors = 4'b0100;
        push(S_COOL, M_FWD, 1'b0, 71, 80, "t3_cool");
        drain("t3b", 100);

        // 4: power loss mid-cooling, then restart from a fresh decision
        run(10);
        power = 1'b0; detectors = 4'b0000; last_cyc = cycle;
        push(S_WAIT, M_STOP, 1'b0, 1, 1, "t4_off");
        drain("t4a", 5);
        run(4);
        power = 1'b1; last_cyc = cycle;
        push(S_TURN, M_RGHT, BEACON_BUILD, 1, 1, "t4_turn");
        drain("t4b", 5);
        detectors = 4'b0100;
        push(S_COOL, M_FWD, 1'b0, 31, 40, "t4_cool");
        push(S_MOVE, M_FWD, 1'b0, 30, 30, "t4_move");
        drain("t4c", 100);

        // Left turn; front still blocked so cooling exits at once and re-decides
        detectors = 4'b0101; last_cyc = cycle;
        push(S_TURN, M_LEFT, 1'b0, 3, 3, "t5_left");
        push(S_COOL, M_FWD, 1'b0, 31, 40, "t5_cool");
        push(S_MOVE, M_FWD, 1'b0, 1, 1, "t5_cool_exit");
        push(S_TURN, M_LEFT, 1'b0, 1, 1, "t5_reeval");
        drain("t5a", 60);
        detectors = 4'b0100;
        push(S_COOL, M_FWD, 1'b0, 31, 40, "t5_cool2");
        push(S_MOVE, M_FWD, 1'b0, 30, 30, "t5_move");
        drain("t5b", 100);

        // 5: asynchronous reset mid-turn, then exact tick phase after release
        detectors = 4'b0001; last_cyc = cycle;
        push(S_TURN, M_RGHT, BEACON_BUILD, 3, 3, "t6_turn");
        drain("t6a", 10);
        run(12);
        #3 rst = 1'b0;
        #1;
        chk("t6_async_state", {30'b0, state}, {30'b0, S_WAIT});
        chk("t6_async_moving", {28'b0, moving_state}, {28'b0, M_STOP});
        chk("t6_async_beacon", {31'b0, pl_beacon_sig}, 32'd0);
        last_st = S_WAIT; last_mv = M_STOP;
        power = 1'b0;
        run(2);
        #2 rst = 1'b1;
        run(5);
        power = 1'b1; last_cyc = cycle;
        push(S_TURN, M_RGHT, BEACON_BUILD, 1, 1, "t6_restart");
        drain("t6b", 5);
        detectors = 4'b0100;
        push(S_COOL, M_FWD, 1'b0, 35, 35, "t6_cool");
        push(S_MOVE, M_FWD, 1'b0, 30, 30, "t6_move");
        drain("t6c", 100);

        // Leaving auto mode via global_state
        global_state = 2'b10; last_cyc = cycle;
        push(S_WAIT, M_STOP, 1'b0, 1, 1, "t7_manual");
        drain("t7", 5);
        run(3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/auto_nav_sequencer.md
Name: auto_nav_sequencer

Overview:
Sequencer for the car's autonomous-driving mode. It turns the four obstacle detectors into a timed MOVING / TURNING / COOLING / WAITING sequence, and drives the state and moving-state codes consumed by the motion datapath. The block is active only when power is on and global_state selects auto mode. It uses a right-hand-wall decision rule and a tick-based turn and cool-down timer.

Parameters:
CLK_FREQ_HZ, 100000000, sys_clk frequency
TICK_HZ, 50, timer tick rate (20 ms tick)
TURN_TICKS, 45, ticks held in TURNING for a 90-degree turn
COOL_TICKS, 25, ticks driven forward after a turn with detectors ignored

Ports:
sys_clk  in  1  system clock
rst  in  1  asynchronous, active-low reset
power  in  1  car power on
global_state  in  2  top-level mode; 2'b01 = auto
detectors  in  4  obstacle flags, 1 = blocked; front=4'b0001, back=4'b0010, right=4'b0100, left=4'b1000
state  out  2  WAITING=00, MOVING=01, TURNING=10, COOLING=11
moving_state  out  4  STOP=0000, MOVE_FORWARD=0001, TURN_LEFT=0100, TURN_RIGHT=1000
pl_beacon_sig  out  1  one-cycle beacon-place pulse (optional feature)

Behaviour:
- Reset (rst=0, asynchronous) sets:
  - state=WAITING, moving_state=STOP, pl_beacon_sig=0
  - tick counter, turn/cool counters and latched detector pattern all cleared.
- Definitions:
  - en = power & (global_state==2'b01).
  - detectors pass through a 2-FF synchroniser; this synchronised value is "det".
  - tick = one-cycle pulse every CLK_FREQ_HZ/TICK_HZ sys_clk cycles, free-running out of reset.
- Decision function, applied to det:
  - right open -> TURN_RIGHT
  - else front open -> MOVE_FORWARD
  - else left open -> TURN_LEFT
  - else (dead end) -> TURN_RIGHT with turn length 2*TURN_TICKS (U-turn).
  - The back bit is ignored by the decision.
- en low in any state: next cycle state=WAITING, moving_state=STOP, counters cleared. This has priority over every transition below.
- WAITING, en high: evaluate the decision.
  - MOVE_FORWARD -> MOVING.
  - Turn -> TURNING with direction latched and turn_cnt=0.
  - Latch det.
- MOVING: moving_state=MOVE_FORWARD. Re-evaluate on any cycle where det differs from the latched pattern, or front is blocked.
  - Forward result: stay in MOVING and update the latch.
  - Turn result: go to TURNING.
- TURNING: moving_state=latched direction. turn_cnt increments on tick. At tick with turn_cnt==limit-1, go to COOLING with cool_cnt=0.
- COOLING: moving_state=MOVE_FORWARD; detectors are ignored except front.
  - At tick with cool_cnt==COOL_TICKS-1: go to MOVING and latch det.
  - Front blocked: go to MOVING immediately; re-evaluation follows on the next cycle.
- Latency:
  - detector edge to state change is 3 sys_clk cycles (2 sync + 1 registered FSM).
  - en change to outputs is 1 cycle.
- All outputs are registered; state and moving_state always change together.
- A tick coinciding with an en drop: the en drop wins and the counter does not advance.

Optional Feature:
Macro AUTO_BEACON_EN.
- Defined: pl_beacon_sig pulses high for exactly one cycle on the cycle the FSM enters TURNING, provided at least two of {front, right, left} were open at decision time (junction). No pulse for a dead-end U-turn.
- Undefined: pl_beacon_sig is tied to 0 and no junction logic is built.

Decomposition:
- Package auto_nav_pkg holds: state codes, moving-state codes, detector bit masks, and the decision function.
- Sub-module nav_tick_gen (parameters CLK_FREQ_HZ, TICK_HZ; ports sys_clk, rst, tick) generates the tick.
- FSM, counters and synchroniser stay in auto_nav_sequencer.

Test Plan (CLK_FREQ_HZ=1000, TICK_HZ=100 -> tick every 10 cycles, TURN_TICKS=4, COOL_TICKS=3):
1. en=1, detectors=4'b0001 -> 3 cycles later TURNING/TURN_RIGHT; held 4 ticks; then COOLING/MOVE_FORWARD for 3 ticks; then MOVING/0001.
2. en=1, detectors=4'b0100 -> MOVING/MOVE_FORWARD, with no TURNING for 20 ticks.
3. detectors=4'b1101 while MOVING -> TURNING/TURN_RIGHT for 8 ticks, then COOLING.
4. power=0 mid-COOLING -> next cycle WAITING/STOP; power=1 again restarts from decision with fresh counters.
5. rst=0 mid-TURNING (asynchronous, not clock-aligned) -> state=00, moving_state=0000 immediately; no tick-count carry-over after release.
6. AUTO_BEACON_EN defined, detectors=4'b0000 at en rise -> pl_beacon_sig=1 for one cycle coincident with entry to TURNING. With 4'b1101 -> no pulse. Macro undefined -> pl_beacon_sig stays 0 throughout.
